// File: rtl/word_narrow_pkg.sv
// Shared types and default widths for the word narrower.
package word_narrow_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int WN_DEF_N = 16;
    localparam int WN_DEF_M = 32;

endpackage

// File: rtl/word_narrow.sv
// Word narrower: takes an M-bit word and emits it least-significant beat first as M/N beats of N bits; WORD_NARROW_ZERO_SKIP_EN sends zero-extended words as a single beat.
// Latency: first beat valid one cycle after input acceptance; one beat per cycle sustained, back-to-back words with no bubble.
// Backpressure: out_ready low freezes the current beat; in_ready is high only when idle or while the final beat is leaving.
module word_narrow
    import word_narrow_pkg::*;
#(
    parameter int N = WN_DEF_N,
    parameter int M = WN_DEF_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         out_last
);

    localparam int BEATS = M / N;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    if (((M % N) != 0) || (BEATS < 2)) begin : g_bad_cfg
        $error("word_narrow: M must be an integer multiple of N with M/N >= 2");
    end

    state_t        state_q, state_d;
    logic [M-1:0]  buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;

    logic in_xfer;
    logic beat_xfer;
    logic load_last;

`ifdef WORD_NARROW_ZERO_SKIP_EN
    // A word whose upper beats are all zero is a zero-extended narrow value.
    assign load_last = ~|data_in[M-1:N];
`else
    assign load_last = 1'b0;
`endif

    assign out_valid = (state_q == SEND);
    assign out_last  = last_q;
    assign beat_xfer = out_valid && out_ready;
    assign in_ready  = (state_q == IDLE) || (beat_xfer && last_q);
    assign in_xfer   = in_valid && in_ready;
    assign data_out  = out_valid ? buf_q[int'(cnt_q) * N +: N] : '0;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        // in_xfer can only fire when idle or on the final beat, so loading wins.
        if (in_xfer) begin
            state_d = SEND;
            buf_d   = data_in;
            cnt_d   = '0;
            last_d  = load_last;
        end else if (beat_xfer) begin
            if (last_q) begin
                state_d = IDLE;
                cnt_d   = '0;
                last_d  = 1'b0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                last_d = (cnt_d == LAST_CNT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_word_narrow.sv
// Bench for word_narrow: a 16-bit-beat and an 8-bit-beat instance checked every cycle against a beat-queue model.
module tb_word_narrow;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        out_ready;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_last;
    logic [15:0] dout16;
    logic [7:0]  dout8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: per instance, a circular list of beats still owed to the sink.
    logic [15:0] md [2][16];
    bit          ml [2][16];
    int          hd [2];
    int          tl [2];
    bit          ix [2];
    bit          ox [2];
    bit          rs        = 1'b1;
    bit          rst_seen  = 1'b0;
    logic [31:0] din_s;

    // Log of beats actually handed to the sink.
    logic [15:0] lg_d [2][32];
    bit          lg_l [2][32];
    int          lg_c [2][32];
    int          lg_n [2];

    logic [15:0] exp35 [4];
    logic [7:0]  exp39 [4];

    word_narrow #(.N(16), .M(32)) u_d16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .data_in   (data_in),
        .out_valid (out_valid[0]),
        .out_ready (out_ready),
        .data_out  (dout16),
        .out_last  (out_last[0])
    );

    word_narrow #(.N(8), .M(32)) u_d8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .data_in   (data_in),
        .out_valid (out_valid[1]),
        .out_ready (out_ready),
        .data_out  (dout8),
        .out_last  (out_last[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_word(input int id, input logic [31:0] w);
        int nn;
        int beats;
        logic [31:0] mask;
        nn    = (id == 0) ? 16 : 8;
        beats = 32 / nn;
        mask  = (32'h1 << nn) - 32'h1;
`ifdef WORD_NARROW_ZERO_SKIP_EN
        if ((w >> nn) == 32'h0) beats = 1;
`endif
        for (int b = 0; b < beats; b++) begin
            md[id][tl[id] % 16] = 16'((w >> (b * nn)) & mask);
            ml[id][tl[id] % 16] = (b == beats - 1);
            tl[id]++;
        end
    endtask

    // Compare process: outputs are stable half a cycle after the inputs move.
    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) begin
            int cnt;
            logic [15:0] dv;
            cnt = tl[id] - hd[id];
            dv  = (id == 0) ? dout16 : {8'h00, dout8};
            chk((id == 0) ? "d16 out_valid" : "d8 out_valid", {31'h0, out_valid[id]}, {31'h0, cnt != 0});
            chk((id == 0) ? "d16 in_ready" : "d8 in_ready", {31'h0, in_ready[id]},
                {31'h0, (cnt == 0) || (cnt == 1 && out_ready)});
            if (cnt != 0) begin
                chk((id == 0) ? "d16 data_out" : "d8 data_out", {16'h0, dv}, {16'h0, md[id][hd[id] % 16]});
                chk((id == 0) ? "d16 out_last" : "d8 out_last", {31'h0, out_last[id]}, {31'h0, ml[id][hd[id] % 16]});
            end
            if (rst_seen) begin
                chk((id == 0) ? "d16 reset data" : "d8 reset data", {16'h0, dv}, 32'h0);
                chk((id == 0) ? "d16 reset last" : "d8 reset last", {31'h0, out_last[id]}, 32'h0);
            end
            ix[id] = in_valid[id] && ((cnt == 0) || (cnt == 1 && out_ready));
            ox[id] = (cnt != 0) && out_ready;
            if (ox[id] && rst_n && lg_n[id] < 32) begin
                lg_d[id][lg_n[id]] = dv;
                lg_l[id][lg_n[id]] = out_last[id];
                lg_c[id][lg_n[id]] = cyc;
                lg_n[id]++;
            end
        end
        din_s = data_in;
        rs    = !rst_n;
    end

    always @(posedge clk) begin
        cyc++;
        for (int id = 0; id < 2; id++) begin
            if (rs) begin
                hd[id] = 0;
                tl[id] = 0;
            end else begin
                if (ox[id]) hd[id]++;
                if (ix[id]) push_word(id, din_s);
            end
        end
        rst_seen = rs;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        lg_n[0] = 0;
        lg_n[1] = 0;
    endtask

    // Offer a word and return in the cycle after it was accepted.
    task automatic send(input int id, input logic [31:0] w);
        bit acc;
        acc          = 1'b0;
        in_valid[id] = 1'b1;
        data_in      = w;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready[id];
            @(posedge clk);
            #1;
        end
        in_valid[id] = 1'b0;
        if (!acc) chk("send timeout", 32'h0, 32'h1);
    endtask

    initial begin
        exp35 = '{16'h2222, 16'h1111, 16'h4444, 16'h3333};
        exp39 = '{8'h04, 8'h03, 8'h02, 8'h01};
        rst_n     = 1'b0;
        in_valid  = 2'b00;
        out_ready = 1'b0;
        data_in   = 32'h0;
        hd = '{0, 0};
        tl = '{0, 0};
        lg_n = '{0, 0};
        cycles(3);

        @(negedge clk);
        chk("reset out_valid", {30'h0, out_valid}, 32'h0);
        chk("reset in_ready", {30'h0, in_ready}, 32'h3);
        chk("reset data_out", {dout16, 8'h0, dout8}, 32'h0);
        chk("reset out_last", {30'h0, out_last}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);

        // Basic word, sink always ready.
        out_ready = 1'b1;
        clr_log();
        send(0, 32'hDEADBEEF);
        @(negedge clk);
        chk("dead beat0", {16'h0, dout16}, 32'hBEEF);
        chk("dead last0", {31'h0, out_last[0]}, 32'h0);
        chk("dead in_ready0", {31'h0, in_ready[0]}, 32'h0);
        @(negedge clk);
        chk("dead beat1", {16'h0, dout16}, 32'hDEAD);
        chk("dead last1", {31'h0, out_last[0]}, 32'h1);
        chk("dead in_ready1", {31'h0, in_ready[0]}, 32'h1);
        @(posedge clk);
        #1;
        cycles(2);

        // Back-to-back words with no bubble.
        clr_log();
        send(0, 32'h11112222);
        send(0, 32'h33334444);
        cycles(4);
        chk("b2b count", lg_n[0], 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b data", {16'h0, lg_d[0][i]}, {16'h0, exp35[i]});
            chk("b2b cycle", lg_c[0][i], lg_c[0][0] + i);
            chk("b2b last", {31'h0, lg_l[0][i]}, {31'h0, (i % 2) == 1});
        end

        // Stall on beat 0.
        out_ready = 1'b0;
        clr_log();
        send(0, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall data", {16'h0, dout16}, 32'hF00D);
            chk("stall in_ready", {31'h0, in_ready[0]}, 32'h0);
            chk("stall out_valid", {31'h0, out_valid[0]}, 32'h1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        cycles(3);
        chk("stall count", lg_n[0], 32'd2);
        chk("stall beat0", {16'h0, lg_d[0][0]}, 32'hF00D);
        chk("stall beat1", {16'h0, lg_d[0][1]}, 32'hCAFE);

        // Reset mid-word discards the rest.
        clr_log();
        send(0, 32'hAAAA5555);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst out_valid", {31'h0, out_valid[0]}, 32'h0);
        chk("midrst in_ready", {31'h0, in_ready[0]}, 32'h1);
        @(posedge clk);
        #1;
        cycles(3);
        chk("midrst count", lg_n[0], 32'd1);
        chk("midrst beat0", {16'h0, lg_d[0][0]}, 32'h5555);

        // Zero-extended word.
        clr_log();
        send(0, 32'h00001234);
        cycles(3);
`ifdef WORD_NARROW_ZERO_SKIP_EN
        chk("zext count", lg_n[0], 32'd1);
        chk("zext beat0", {16'h0, lg_d[0][0]}, 32'h1234);
        chk("zext last0", {31'h0, lg_l[0][0]}, 32'h1);
`else
        chk("zext count", lg_n[0], 32'd2);
        chk("zext beat0", {16'h0, lg_d[0][0]}, 32'h1234);
        chk("zext last0", {31'h0, lg_l[0][0]}, 32'h0);
        chk("zext beat1", {16'h0, lg_d[0][1]}, 32'h0000);
        chk("zext last1", {31'h0, lg_l[0][1]}, 32'h1);
`endif

        // Four 8-bit beats.
        clr_log();
        send(1, 32'h01020304);
        cycles(5);
        chk("n8 count", lg_n[1], 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("n8 data", {16'h0, lg_d[1][i]}, {24'h0, exp39[i]});
            chk("n8 last", {31'h0, lg_l[1][i]}, {31'h0, i == 3});
        end

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 3);
            in_valid  = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            data_in   = (r == 0) ? {16'h0, 16'($urandom)} :
                        (r == 1) ? {24'h0, 8'($urandom)} : 32'($urandom);
            rst_n     = ($urandom_range(0, 299) != 0);
            cycles(1);
        end
        in_valid  = 2'b00;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        cycles(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
